muldiv_unit: RTL and testbench

Parametrised RV32M/RV64M multiply/divide execution unit; successor to the fixed 32-bit mult/div stage. Accepts one M-extension operation at a time through a valid/ready request port. Multiplies complete in a configurable number of cycles; divides use an iterative radix-2 restoring divider. Returns a tagged result through a valid/ready response port, and a value-compared result cache fuses MULH*/MUL and DIV*/REM* pairs. Sits beside the ALU in the execute stage and feeds the mem-stage writeback mux.

---
 rtl/muldiv_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M/RV64M multiply/divide execution unit.
// One operation in flight at a time. Multiplies complete after MUL_LAT cycles
// and divides use an XLEN-step radix-2 restoring divider with a sign-fix step.
// Divide by zero and signed overflow finish in one cycle.
// Optional feature macro: MULDIV_FUSE_EN adds a one-entry result cache. It lets
// MULH*/MUL and DIV*/REM* pairs on the same operands reuse one computation.
module muldiv_unit #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             cpurst_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [XLEN-1:0]  req_opa,
    input  logic [XLEN-1:0]  req_opb,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [2:0]         op_q;
    logic [XLEN-1:0]    opa_q, opb_q;
    logic [TAG_W-1:0]   tag_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [XLEN-1:0]    quo_q, rem_q, dvs_q;
    logic [XLEN-1:0]    resData_q;

    logic               accept;
    logic               enterDone;
    logic [2:0]         opS;
    logic [XLEN-1:0]    opaS, opbS;
    logic               mulASigned, mulBSigned, mulNeg;
    logic [XLEN-1:0]    mulMagA, mulMagB;
    logic [2*XLEN-1:0]  mulMagProd, mulProd;
    logic               divSigned, divZero, divOvf;
    logic [XLEN-1:0]    divMagA, divMagB;
    logic [XLEN:0]      remShift, remDiff;
    logic               quoNeg, remNeg;
    logic [XLEN-1:0]    finHi, finLo, finData;
    logic               cacheHit;
    logic [XLEN-1:0]    hitHi, hitLo, hitData;

    assign accept    = req_valid && req_ready;
    assign enterDone = (state_d == S_DONE) && (state_q != S_DONE);

    // Operands come straight from the request while idle, from the latches otherwise
    always_comb begin
        opS  = (state_q == S_IDLE) ? req_op  : op_q;
        opaS = (state_q == S_IDLE) ? req_opa : opa_q;
        opbS = (state_q == S_IDLE) ? req_opb : opb_q;
    end

    // Sign-magnitude multiplier and divider operand preparation and sign fix-up
    always_comb begin
        mulASigned = (opS == 3'd1) || (opS == 3'd2);
        mulBSigned = (opS == 3'd1);
        mulNeg     = (mulASigned && opaS[XLEN-1]) ^ (mulBSigned && opbS[XLEN-1]);
        mulMagA    = (mulASigned && opaS[XLEN-1]) ? -opaS : opaS;
        mulMagB    = (mulBSigned && opbS[XLEN-1]) ? -opbS : opbS;
        mulMagProd = {{XLEN{1'b0}}, mulMagA} * {{XLEN{1'b0}}, mulMagB};
        mulProd    = mulNeg ? -mulMagProd : mulMagProd;

        divSigned  = ~opS[0];
        divZero    = (opbS == '0);
        divOvf     = divSigned && (opaS == {1'b1, {(XLEN-1){1'b0}}}) && (opbS == '1);
        divMagA    = (divSigned && opaS[XLEN-1]) ? -opaS : opaS;
        divMagB    = (divSigned && opbS[XLEN-1]) ? -opbS : opbS;
        remShift   = {rem_q, quo_q[XLEN-1]};
        remDiff    = remShift - {1'b0, dvs_q};
        quoNeg     = divSigned && (opaS[XLEN-1] ^ opbS[XLEN-1]);
        remNeg     = divSigned && opaS[XLEN-1];
    end

    // Both result halves (hi/lo or quotient/remainder) and the half the op returns
    always_comb begin
        if (opS[2]) begin
            if (state_q == S_FIX) begin
                finHi = quoNeg ? -quo_q : quo_q;
                finLo = remNeg ? -rem_q : rem_q;
            end else begin
                finHi = divZero ? '1 : opaS;
                finLo = divZero ? opaS : '0;
            end
            finData = opS[1] ? finLo : finHi;
            hitData = opS[1] ? hitLo : hitHi;
        end else begin
            finHi   = mulProd[2*XLEN-1:XLEN];
            finLo   = mulProd[XLEN-1:0];
            finData = (opS[1:0] == 2'd0) ? finLo : finHi;
            hitData = (opS[1:0] == 2'd0) ? hitLo : hitHi;
        end
    end

`ifdef MULDIV_FUSE_EN
    logic             cValid_q;
    logic [2:0]       cOp_q;
    logic [XLEN-1:0]  cOpa_q, cOpb_q, cHi_q, cLo_q;

    assign hitHi = cHi_q;
    assign hitLo = cLo_q;

    // Hit when the operands match and the cached entry holds the wanted half
    always_comb begin
        cacheHit = 1'b0;
        if (cValid_q && (state_q == S_IDLE) && (opaS == cOpa_q) && (opbS == cOpb_q)) begin
            if (opS[2]) begin
                cacheHit = cOp_q[2] && (cOp_q[0] == opS[0]);
            end else begin
                cacheHit = !cOp_q[2] && ((opS == 3'd0) || (cOp_q == opS));
            end
        end
    end

    // Capture every freshly computed result; a flush forgets the entry
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            cValid_q <= 1'b0;
            cOp_q    <= '0;
            cOpa_q   <= '0;
            cOpb_q   <= '0;
            cHi_q    <= '0;
            cLo_q    <= '0;
        end else if (flush) begin
            cValid_q <= 1'b0;
        end else if (enterDone && !cacheHit) begin
            cValid_q <= 1'b1;
            cOp_q    <= opS;
            cOpa_q   <= opaS;
            cOpb_q   <= opbS;
            cHi_q    <= finHi;
            cLo_q    <= finLo;
        end
    end
`else
    assign cacheHit = 1'b0;
    assign hitHi    = '0;
    assign hitLo    = '0;
`endif

    // State register
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Next-state logic; flush always returns to idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (cacheHit)               state_d = S_DONE;
                    else if (!req_op[2])        state_d = (MUL_LAT == 1) ? S_DONE : S_MUL;
                    else if (divZero || divOvf) state_d = S_DONE;
                    else                        state_d = S_DIV;
                end
            end
            S_MUL:   if (int'(cnt_q) == MUL_LAT - 2) state_d = S_DONE;
            S_DIV:   if (int'(cnt_q) == XLEN - 1)    state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    // Handshake and status outputs decoded from the state
    always_comb begin
        req_ready  = (state_q == S_IDLE) && !flush;
        resp_valid = (state_q == S_DONE);
        busy       = (state_q != S_IDLE);
        resp_data  = resData_q;
        resp_tag   = tag_q;
    end

    // Operand latch, latency counter, divider iteration and result capture
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            op_q      <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            tag_q     <= '0;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            resData_q <= '0;
        end else begin
            if (accept) begin
                op_q  <= req_op;
                opa_q <= req_opa;
                opb_q <= req_opb;
                tag_q <= req_tag;
                cnt_q <= '0;
                quo_q <= divMagA;
                rem_q <= '0;
                dvs_q <= divMagB;
            end else if ((state_q == S_MUL) || (state_q == S_DIV)) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (state_q == S_DIV) begin
                    if (!remDiff[XLEN]) begin
                        rem_q <= remDiff[XLEN-1:0];
                        quo_q <= {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_q <= remShift[XLEN-1:0];
                        quo_q <= {quo_q[XLEN-2:0], 1'b0};
                    end
                end
            end
            if (enterDone) begin
                resData_q <= cacheHit ? hitData : finData;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed bench for muldiv_unit (XLEN=32, MUL_LAT=2).
// A compare process checks handshake, latency, data and tag every cycle
// against a plain-arithmetic model; literal expectations pin the model.
module tb_muldiv_unit;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;
    localparam int TAG_W   = 5;
    localparam int DIV_LAT = XLEN + 2;
`ifdef MULDIV_FUSE_EN
    localparam int FUSED_LAT_MUL = 1;
    localparam int FUSED_LAT_DIV = 1;
`else
    localparam int FUSED_LAT_MUL = MUL_LAT;
    localparam int FUSED_LAT_DIV = DIV_LAT;
`endif

    logic             clk;
    logic             cpurst_n;
    logic             flush;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [XLEN-1:0]  req_opa;
    logic [XLEN-1:0]  req_opb;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready;
    logic [XLEN-1:0]  resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic             busy;

    int compareCount  = 0;
    int mismatchCount = 0;

    bit               monOn   = 0;
    bit               pending = 0;
    int               cyc     = 0;
    int               expLat  = 0;
    logic [31:0]      expData = '0;
    logic [TAG_W-1:0] expTag  = '0;

    bit          mcValid = 0;
    logic [2:0]  mcOp    = '0;
    logic [31:0] mcA     = '0;
    logic [31:0] mcB     = '0;
    bit          lastHit = 0;
    logic [2:0]  lastOp  = '0;
    logic [31:0] lastA   = '0;
    logic [31:0] lastB   = '0;

    muldiv_unit #(.XLEN(XLEN), .MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .cpurst_n   (cpurst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_opa    (req_opa),
        .req_opb    (req_opb),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        compareCount++;
        if (act !== exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of an M-extension op using wide plain arithmetic
    function automatic logic [31:0] modelResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, za, zb, p;
        int ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        za = {32'b0, a};
        zb = {32'b0, b};
        ia = a;
        ib = b;
        case (op)
            3'd0: begin p = za * zb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * zb; return p[63:32]; end
            3'd3: begin p = za * zb; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(ia / ib);
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Whether the remembered previous result can serve this op
    function automatic bit modelHit(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FUSE_EN
        bit reqIsDiv, entIsDiv, reqSignedDiv, entSignedDiv;
        if (!mcValid || a != mcA || b != mcB) return 0;
        reqIsDiv     = (op >= 3'd4);
        entIsDiv     = (mcOp >= 3'd4);
        reqSignedDiv = (op == 3'd4) || (op == 3'd6);
        entSignedDiv = (mcOp == 3'd4) || (mcOp == 3'd6);
        if (reqIsDiv) return entIsDiv && (reqSignedDiv == entSignedDiv);
        if (entIsDiv) return 0;
        return (op == 3'd0) || (op == mcOp);
`else
        return (op == 3'd7) && (a != a);
`endif
    endfunction

    function automatic int modelLat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (modelHit(op, a, b)) return 1;
        if (op < 3'd4) return MUL_LAT;
        if (b == 32'd0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return DIV_LAT;
    endfunction

    // Per-cycle compare of DUT outputs against the model's expectation
    always @(negedge clk) begin
        if (monOn) begin
            if (pending) begin
                cyc++;
                checkVal("busy_while_op", busy, 1'b1);
                checkVal("req_ready_while_op", req_ready, 1'b0);
                checkVal("resp_valid_timing", resp_valid, (cyc >= expLat));
                if (resp_valid && cyc >= expLat) begin
                    checkVal("resp_data", resp_data, expData);
                    checkVal("resp_tag", resp_tag, expTag);
                end
            end else begin
                checkVal("idle_resp_valid", resp_valid, 1'b0);
                checkVal("idle_busy", busy, 1'b0);
                checkVal("idle_req_ready", req_ready, !flush);
            end
        end
    end

    // Present a request and let it be accepted on the next rising edge
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [TAG_W-1:0] tag, input logic [31:0] litData, input int litLat);
        lastHit = modelHit(op, a, b);
        lastOp  = op;
        lastA   = a;
        lastB   = b;
        expData = modelResult(op, a, b);
        expLat  = modelLat(op, a, b);
        expTag  = tag;
        checkVal("model_pin_data", expData, litData);
        checkVal("model_pin_lat", expLat, litLat);
        req_valid = 1'b1;
        req_op    = op;
        req_opa   = a;
        req_opb   = b;
        req_tag   = tag;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cyc       = 0;
        pending   = 1'b1;
    endtask

    // Wait for the response, stall it for 'hold' cycles, then take it
    task automatic checkOutput(input int hold);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!resp_valid && k < 200);
        if (!resp_valid) checkVal("resp_timeout", resp_valid, 1'b1);
        repeat (hold) @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        pending    = 1'b0;
        if (!lastHit) begin
            mcValid = 1'b1;
            mcOp    = lastOp;
            mcA     = lastA;
            mcB     = lastB;
        end
    endtask

    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag, input logic [31:0] litData, input int litLat,
                         input int hold);
        applyStimulus(op, a, b, tag, litData, litLat);
        checkOutput(hold);
    endtask

    initial begin
        cpurst_n   = 1'b0;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_op     = '0;
        req_opa    = '0;
        req_opb    = '0;
        req_tag    = '0;
        resp_ready = 1'b0;
        #1;
        checkVal("reset_req_ready", req_ready, 1'b1);
        checkVal("reset_resp_valid", resp_valid, 1'b0);
        checkVal("reset_resp_data", resp_data, 32'h0);
        checkVal("reset_resp_tag", resp_tag, 5'h0);
        checkVal("reset_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        cpurst_n = 1'b1;
        monOn    = 1'b1;

        runOp(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 5'd5,  32'hFFFF_FFFE, MUL_LAT, 5);
        runOp(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 5'd6,  32'hFFFF_FFFF, MUL_LAT, 0);
        runOp(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, MUL_LAT, 0);
        runOp(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'h0000_0001, FUSED_LAT_MUL, 0);
        runOp(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd9,  32'hFFFF_FFFF, MUL_LAT, 0);
        runOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, MUL_LAT, 0);
        runOp(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd11, 32'hFFFF_FFFD, DIV_LAT, 0);
        runOp(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd12, 32'hFFFF_FFFF, FUSED_LAT_DIV, 0);
        runOp(3'd7, 32'hFFFF_FFF9, 32'h0000_0002, 5'd13, 32'h0000_0001, DIV_LAT, 0);
        runOp(3'd5, 32'h0000_0007, 32'h0000_0000, 5'd14, 32'hFFFF_FFFF, 1, 2);
        runOp(3'd7, 32'h0000_0007, 32'h0000_0000, 5'd15, 32'h0000_0007, 1, 0);
        runOp(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1, 0);
        runOp(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0000_0000, 1, 0);
        runOp(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h0000_0000, DIV_LAT, 0);
        runOp(3'd6, 32'h0000_0007, 32'hFFFF_FFFD, 5'd19, 32'h0000_0001, DIV_LAT, 0);
        runOp(3'd5, 32'hFFFF_FFFF, 32'h0000_0010, 5'd20, 32'h0FFF_FFFF, DIV_LAT, 0);
        runOp(3'd4, 32'd100,       32'd7,         5'd21, 32'd14,        DIV_LAT, 0);

        // Kill a divide in its tenth iteration; nothing must come back
        applyStimulus(3'd5, 32'd50, 32'd3, 5'd30, 32'd16, DIV_LAT);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush   = 1'b0;
        pending = 1'b0;
        mcValid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        runOp(3'd6, 32'd100, 32'd7, 5'd22, 32'd2, DIV_LAT, 0);

        // A request alongside flush must be refused
        flush     = 1'b1;
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_opa   = 32'd9;
        req_opb   = 32'd9;
        req_tag   = 5'd31;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        mcValid   = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a multiply
        applyStimulus(3'd0, 32'd3, 32'd5, 5'd9, 32'd15, MUL_LAT);
        monOn = 1'b0;
        #3;
        cpurst_n = 1'b0;
        #1;
        checkVal("midreset_req_ready", req_ready, 1'b1);
        checkVal("midreset_resp_valid", resp_valid, 1'b0);
        checkVal("midreset_resp_data", resp_data, 32'h0);
        checkVal("midreset_resp_tag", resp_tag, 5'h0);
        checkVal("midreset_busy", busy, 1'b0);
        pending = 1'b0;
        mcValid = 1'b0;
        @(posedge clk);
        #1;
        cpurst_n = 1'b1;
        monOn    = 1'b1;
        @(posedge clk);
        #1;

        runOp(3'd3, 32'h8000_0000, 32'h0000_0004, 5'd23, 32'h0000_0002, MUL_LAT, 0);
        runOp(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd24, 32'h4000_0000, MUL_LAT, 0);

        repeat (3) @(posedge clk);
        #1;
        monOn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

    initial begin
        #500000;
        mismatchCount++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
